// File: rtl/dpram_pkg.sv
// Shared defaults and port roles for the 16x8 dual-port RAM and its FIFO controller.
package dpram_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 4;

  // Port A is the write-only side, port B the read-only side.
  localparam bit PortAWrites = 1'b1;
  localparam bit PortBWrites = 1'b0;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop streams plus the RAM port signals driven by the FIFO controller.
interface dpram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = dpram_pkg::DefaultDataW,
  parameter int unsigned ADDR_W = dpram_pkg::DefaultAddrW
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W+1:0] count;
  logic              wr_enA;
  logic [ADDR_W-1:0] addr_A;
  logic [DATA_W-1:0] wr_dataA;
  logic              wr_enB;
  logic [ADDR_W-1:0] addr_B;
  logic [DATA_W-1:0] rd_dataB;

  modport master (
    input  s_valid, s_data, m_ready, rd_dataB,
    output s_ready, m_valid, m_data, count, wr_enA, addr_A, wr_dataA, wr_enB, addr_B
  );

  modport slave (
    output s_valid, s_data, m_ready, rd_dataB,
    input  s_ready, m_valid, m_data, count, wr_enA, addr_A, wr_dataA, wr_enB, addr_B
  );

endinterface

// File: rtl/dpram_16x8.sv
// Dual-port RAM, synchronous read on port B; each port writes only if its role allows.
module dpram_16x8 import dpram_pkg::*; #(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);

  localparam int unsigned Depth = depth(ADDR_W);

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (PortAWrites && we_a) begin
      mem[addr_a] <= din_a;
    end
    if (PortBWrites && we_b) begin
      mem[addr_b] <= din_b;
    end
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/dpram_out_buf.sv
// Two-entry register FIFO holding prefetched RAM words; slot 0 is always the head.
module dpram_out_buf #(
  parameter int unsigned DATA_W = dpram_pkg::DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        out_cnt
);

  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (pop && (cnt_q != 2'd0)) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    // Capture lands behind whatever survives the pop, so capture+pop works at any fill.
    if (capture && (cnt_d != 2'd2)) begin
      if (cnt_d == 2'd0) begin
        slot0_d = din;
      end else begin
        slot1_d = din;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid   = (cnt_q != 2'd0);
  assign head    = slot0_q;
  assign out_cnt = cnt_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller: push stream -> RAM port A writes, port B prefetch -> 2-entry pop buffer.
module dpram_fifo_ctrl import dpram_pkg::*; #(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input logic              clk,
  input logic              rst_n,
  dpram_fifo_ctrl_if.master bus
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(depth(ADDR_W));

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              rd_inflight_q, rd_inflight_d;

  logic              s_ready;
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        occ_after_pop;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        out_cnt;

  assign s_ready = (ram_cnt_q != DepthCnt);
  assign push    = bus.s_valid && s_ready;
  assign pop     = m_valid && bus.m_ready;

  // Only issue when the word has a guaranteed slot: buffer plus in-flight never exceeds 2.
  assign occ_after_pop = 3'(out_cnt) + 3'(rd_inflight_q) - 3'(pop);
  assign issue         = (ram_cnt_q != '0) && (occ_after_pop < 3'd2);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ram_cnt_d     = ram_cnt_q;
    rd_inflight_d = issue;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  dpram_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (rd_inflight_q),
    .din     (bus.rd_dataB),
    .pop     (pop),
    .valid   (m_valid),
    .head    (m_data),
    .out_cnt (out_cnt)
  );

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid;
  assign bus.m_data   = m_data;
  assign bus.count    = (ADDR_W+2)'(ram_cnt_q) + (ADDR_W+2)'(rd_inflight_q)
                      + (ADDR_W+2)'(out_cnt);
  assign bus.wr_enA   = push;
  assign bus.addr_A   = wr_ptr_q;
  assign bus.wr_dataA = bus.s_data;
  assign bus.wr_enB   = 1'b0;
  assign bus.addr_B   = rd_ptr_q;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with the dual-port RAM beside it; queue scoreboard plus vector table.
module tb_dpram_fifo_ctrl;
  import dpram_pkg::*;

  localparam int unsigned DW = DefaultDataW;
  localparam int unsigned AW = DefaultAddrW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] din_b_zero = '0;

  dpram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dpram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dpram_16x8 #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
    .clk    (clk),
    .we_a   (bus.wr_enA),
    .addr_a (bus.addr_A),
    .din_a  (bus.wr_dataA),
    .we_b   (bus.wr_enB),
    .addr_b (bus.addr_B),
    .din_b  (din_b_zero),
    .dout_b (bus.rd_dataB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    logic          exp_sr;
    logic          exp_mv;
    int            exp_cnt;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] sb[$];
  int            pushes = 0;
  int            pops = 0;
  int            wrap_a = 0;
  int            wrap_b = 0;
  logic [AW-1:0] prev_a = '0;
  logic [AW-1:0] prev_b = '0;
  logic [DW-1:0] last_pop = '0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Samples at the falling edge what the next rising edge will transfer.
  task automatic monitor();
    logic [DW-1:0] exp;
    if (!rst_n) begin
      sb.delete();
      return;
    end
    check("count_track", int'(bus.count), sb.size());
    if (bus.m_valid && bus.m_ready) begin
      pops++;
      last_pop = bus.m_data;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_underflow got=%0h want=<nothing queued>", bus.m_data);
      end else begin
        exp = sb.pop_front();
        check("pop_data", int'(bus.m_data), int'(exp));
      end
    end
    if (bus.s_valid && bus.s_ready) begin
      pushes++;
      sb.push_back(bus.s_data);
    end
    if (prev_a == '1 && bus.addr_A == '0) wrap_a++;
    if (prev_b == '1 && bus.addr_B == '0) wrap_b++;
    prev_a = bus.addr_A;
    prev_b = bus.addr_B;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    while (bus.count != '0 && n < 60) begin
      tick();
      n++;
    end
    check(name, int'(bus.count), 0);
  endtask

  initial begin
    vec_t          vt[7];
    logic          acc;
    logic          seen;
    int            acc_cnt;
    int            fall_idx;
    int            gaps;
    int            cyc;
    int            p0;
    int            wa0;
    int            wb0;
    logic [DW-1:0] nxt;

    vt[0] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1, 1'b0, 8'h00};
    vt[1] = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 2, 1'b0, 8'h00};
    vt[2] = '{1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 3, 1'b1, 8'hAA};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2, 1'b1, 8'hBB};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b1, 8'hCC};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset asserted mid-cycle must clear outputs without waiting for a clock.
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_s_ready", int'(bus.s_ready), 1);
    check("rst_wr_enA", int'(bus.wr_enA), 0);
    check("rst_wr_enB", int'(bus.wr_enB), int'(PortBWrites));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      bus.s_valid = vt[i].sv;
      bus.s_data  = vt[i].d;
      bus.m_ready = vt[i].mr;
      tick();
      check($sformatf("vec%0d_s_ready", i), int'(bus.s_ready), int'(vt[i].exp_sr));
      check($sformatf("vec%0d_m_valid", i), int'(bus.m_valid), int'(vt[i].exp_mv));
      check($sformatf("vec%0d_count", i), int'(bus.count), vt[i].exp_cnt);
      if (vt[i].chk_data) begin
        check($sformatf("vec%0d_m_data", i), int'(bus.m_data), int'(vt[i].exp_data));
      end
    end

    // Fill with the consumer stalled.
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b0;
    nxt      = 8'h00;
    acc_cnt  = 0;
    fall_idx = -1;
    for (int i = 0; i < 25; i++) begin
      bus.s_data = nxt;
      acc = bus.s_ready;
      tick();
      if (acc) begin
        nxt++;
        acc_cnt++;
      end
      if (!bus.s_ready && fall_idx < 0) fall_idx = i;
    end
    check("fill_accepted", acc_cnt, 18);
    check("fill_sready_fall", fall_idx, 17);
    check("fill_s_ready", int'(bus.s_ready), 0);
    check("fill_count", int'(bus.count), 18);
    p0 = pops;
    drain("fill_drain");
    check("fill_pops", pops - p0, 18);

    // Streaming across pointer wrap.
    wa0  = wrap_a;
    wb0  = wrap_b;
    p0   = pops;
    nxt  = 8'h40;
    acc_cnt = 0;
    cyc  = 0;
    gaps = 0;
    seen = 1'b0;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    while (acc_cnt < 40 && cyc < 80) begin
      bus.s_data = nxt;
      acc = bus.s_ready;
      tick();
      cyc++;
      if (acc) begin
        nxt++;
        acc_cnt++;
      end
      if (bus.m_valid) seen = 1'b1;
      else if (seen) gaps++;
    end
    check("stream_cycles", cyc, 40);
    check("stream_gaps", gaps, 0);
    drain("stream_drain");
    check("stream_pops", pops - p0, 40);
    check("stream_wrap_a", int'(wrap_a > wa0), 1);
    check("stream_wrap_b", int'(wrap_b > wb0), 1);

    // Full, then a single-cycle pop while the producer keeps pushing.
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b0;
    nxt = 8'h80;
    cyc = 0;
    while (bus.count != 6'd18 && cyc < 40) begin
      bus.s_data = nxt;
      acc = bus.s_ready;
      tick();
      cyc++;
      if (acc) nxt++;
    end
    check("full_count", int'(bus.count), 18);
    bus.s_data  = nxt;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!bus.s_ready) tick();
    end
    check("full_sready_back", int'(bus.s_ready), 1);
    acc = bus.s_ready;
    tick();
    check("full_push_acc", int'(acc), 1);
    check("full_count_again", int'(bus.count), 18);
    drain("full_drain");

    // Reset with five words buffered, then a fresh push.
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_data = 8'hC0 + 8'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    check("mid_count5", int'(bus.count), 5);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_count", int'(bus.count), 0);
    check("mid_rst_m_valid", int'(bus.m_valid), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    p0 = pops;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    cyc = 0;
    while (pops == p0 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("mid_pop_seen", pops - p0, 1);
    check("mid_first_data", int'(last_pop), 8'h5A);
    drain("mid_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
